// File: rtl/ddr3_ring_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ring_pkg
// Purpose  : Shared types and constants for the DDR3 ring-FIFO scheduler:
//            scheduler state encoding, operation identifiers and counter
//            widths.
// Revision : 1.0  initial release
// ============================================================================
package ddr3_ring_pkg;

    localparam int REGION_W = 16;            // ring size in blocks
    localparam int FILL_W   = REGION_W + 1;  // fill must be able to hold region_blocks itself
    localparam int BLOCK_W  = 24;            // dwords per block

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_RUN   = 3'd1,
        ST_WR_DRAIN = 3'd2,
        ST_RD_RUN   = 3'd3,
        ST_RD_DRAIN = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ddr3_ring_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ring_sched_if
// Purpose  : Bundles the configuration, PPFIFO handshake and application-
//            interface signals of the ring scheduler.
//            slave  : scheduler side (consumes i_*, drives o_*)
//            master : surrounding logic (drives i_*, consumes o_*)
// Revision : 1.0  initial release
// ============================================================================
interface ddr3_ring_sched_if
    import ddr3_ring_pkg::*;
#(
    parameter int MEM_ADDR_DEPTH = 28
) ();
    localparam int AW = MEM_ADDR_DEPTH - 2;

    logic                i_enable;
    logic                i_flush;
    logic [AW-1:0]       i_base_dword_addr;
    logic [REGION_W-1:0] i_region_blocks;
    logic [BLOCK_W-1:0]  i_block_dwords;
    logic                i_app_idle;
    logic                i_ingress_rdy;
    logic [1:0]          i_egress_rdy;
    logic                o_ingress_en;
    logic [AW-1:0]       o_ingress_dword_addr;
    logic                i_ingress_stb;
    logic                o_egress_en;
    logic [AW-1:0]       o_egress_dword_addr;
    logic                i_egress_stb;
    logic [FILL_W-1:0]   o_fill_blocks;
    logic                o_full;
    logic                o_empty;
    logic                o_busy;
    logic                o_err;

    modport slave (
        input  i_enable, i_flush, i_base_dword_addr, i_region_blocks,
               i_block_dwords, i_app_idle, i_ingress_rdy, i_egress_rdy,
               i_ingress_stb, i_egress_stb,
        output o_ingress_en, o_ingress_dword_addr, o_egress_en,
               o_egress_dword_addr, o_fill_blocks, o_full, o_empty,
               o_busy, o_err
    );

    modport master (
        output i_enable, i_flush, i_base_dword_addr, i_region_blocks,
               i_block_dwords, i_app_idle, i_ingress_rdy, i_egress_rdy,
               i_ingress_stb, i_egress_stb,
        input  o_ingress_en, o_ingress_dword_addr, o_egress_en,
               o_egress_dword_addr, o_fill_blocks, o_full, o_empty,
               o_busy, o_err
    );

endinterface
`default_nettype wire

// File: rtl/ddr3_ring_sched_ring_ptr.sv
`default_nettype none
// ============================================================================
// Module   : ring_ptr
// Purpose  : One ring pointer: block index plus matching dword address.
//            load    -> index 0, address = base
//            advance -> step one block, wrapping to base at region end
// Ports    : clk, rst, load, advance, base, block_dwords, region_blocks,
//            addr (current block start address)
// Revision : 1.0  initial release
// ============================================================================
module ring_ptr
    import ddr3_ring_pkg::*;
#(
    parameter int AW = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                advance,
    input  logic [AW-1:0]       base,
    input  logic [BLOCK_W-1:0]  block_dwords,
    input  logic [REGION_W-1:0] region_blocks,
    output logic [AW-1:0]       addr
);

    logic [REGION_W-1:0] r_idx;
    logic [AW-1:0]       r_addr;
    logic [AW-1:0]       w_step;
    logic                w_wrap;

    // The address is tracked incrementally so no idx*block multiply is needed.
    generate
        if (AW > BLOCK_W) begin : g_step_wide
            assign w_step = {{(AW-BLOCK_W){1'b0}}, block_dwords};
        end else begin : g_step_narrow
            assign w_step = block_dwords[AW-1:0];
        end
    endgenerate

    assign w_wrap = (({1'b0, r_idx} + (REGION_W+1)'(1)) == {1'b0, region_blocks});
    assign addr   = r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_addr <= '0;
        end else if (load) begin
            r_idx  <= '0;
            r_addr <= base;
        end else if (advance) begin
            if (w_wrap) begin
                r_idx  <= '0;
                r_addr <= base;
            end else begin
                r_idx  <= r_idx + REGION_W'(1);
                r_addr <= r_addr + w_step;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr3_ring_sched.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ring_sched
// Purpose  : Schedules block writes (ingress PPFIFO -> DDR3) and block reads
//            (DDR3 -> egress PPFIFO) so a DDR3 region behaves as a ring FIFO.
//            Arbitrates between the two, counts data strobes, tracks the
//            ring pointers and fill level, flags strobe errors.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            bus (slave)        - config, PPFIFO ready/strobe, app idle,
//                                 enables/addresses, fill and status flags
// Revision : 1.0  initial release
// ============================================================================
module ddr3_ring_sched
    import ddr3_ring_pkg::*;
#(
    parameter int MEM_ADDR_DEPTH = 28
) (
    input  logic             clk,
    input  logic             rst,
    ddr3_ring_sched_if.slave bus
);

    localparam int AW = MEM_ADDR_DEPTH - 2;

    state_t              r_state;
    logic                r_last_op;
    logic                r_init;
    logic [BLOCK_W-1:0]  r_cnt;
    logic [FILL_W-1:0]   r_fill;
    logic                r_full;
    logic                r_empty;
    logic                r_busy;
    logic                r_err;
    logic                r_ingress_en;
    logic                r_egress_en;
    logic [AW-1:0]       r_ingress_addr;
    logic [AW-1:0]       r_egress_addr;

    logic [AW-1:0]       w_wr_addr;
    logic [AW-1:0]       w_rd_addr;
    logic [AW-1:0]       w_wr_start_addr;
    logic [AW-1:0]       w_rd_start_addr;
    logic                w_idle;
    logic                w_flush;
    logic                w_load;
    logic                w_wr_done;
    logic                w_rd_done;
    logic                w_wr_elig;
    logic                w_rd_elig;
    logic                w_take_wr;
    logic                w_take_rd;
    logic                w_stray;
    logic [BLOCK_W:0]    w_cnt_inc;
    logic                w_cnt_last;
    logic [FILL_W-1:0]   w_fill_nxt;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_flush   = bus.i_flush && w_idle;
    // Pointers pick up the base on the first cycle out of reset and on flush.
    assign w_load    = r_init || w_flush;
    assign w_wr_done = (r_state == ST_WR_DRAIN) && bus.i_app_idle;
    assign w_rd_done = (r_state == ST_RD_DRAIN) && bus.i_app_idle;

    assign w_wr_elig = bus.i_enable && !r_full && bus.i_ingress_rdy && bus.i_app_idle;
    assign w_rd_elig = bus.i_enable && !r_empty && (|bus.i_egress_rdy) && bus.i_app_idle;
    assign w_take_wr = w_wr_elig && (!w_rd_elig || (r_last_op == OP_RD));
    assign w_take_rd = w_rd_elig && !w_take_wr;

    // The pointers still hold their reset value during the init cycle, so an
    // operation launched then must use the base directly.
    assign w_wr_start_addr = r_init ? bus.i_base_dword_addr : w_wr_addr;
    assign w_rd_start_addr = r_init ? bus.i_base_dword_addr : w_rd_addr;

    // Any strobe outside its own RUN state is an error; excess strobes land in
    // DRAIN because RUN is left on the strobe that completes the block.
    assign w_stray = (bus.i_ingress_stb && (r_state != ST_WR_RUN)) ||
                     (bus.i_egress_stb  && (r_state != ST_RD_RUN));

    assign w_cnt_inc  = {1'b0, r_cnt} + (BLOCK_W+1)'(1);
    assign w_cnt_last = (w_cnt_inc == {1'b0, bus.i_block_dwords});

    always_comb begin
        w_fill_nxt = r_fill;
        if (w_flush) begin
            w_fill_nxt = '0;
        end else if (w_wr_done) begin
            w_fill_nxt = r_fill + FILL_W'(1);
        end else if (w_rd_done) begin
            w_fill_nxt = r_fill - FILL_W'(1);
        end
    end

    ring_ptr #(.AW(AW)) u_wr_ptr (
        .clk           (clk),
        .rst           (rst),
        .load          (w_load),
        .advance       (w_wr_done),
        .base          (bus.i_base_dword_addr),
        .block_dwords  (bus.i_block_dwords),
        .region_blocks (bus.i_region_blocks),
        .addr          (w_wr_addr)
    );

    ring_ptr #(.AW(AW)) u_rd_ptr (
        .clk           (clk),
        .rst           (rst),
        .load          (w_load),
        .advance       (w_rd_done),
        .base          (bus.i_base_dword_addr),
        .block_dwords  (bus.i_block_dwords),
        .region_blocks (bus.i_region_blocks),
        .addr          (w_rd_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_last_op      <= OP_RD;
            r_init         <= 1'b1;
            r_cnt          <= '0;
            r_fill         <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
            r_ingress_en   <= 1'b0;
            r_egress_en    <= 1'b0;
            r_ingress_addr <= '0;
            r_egress_addr  <= '0;
        end else begin
            r_init  <= 1'b0;
            r_fill  <= w_fill_nxt;
            r_full  <= (w_fill_nxt == {1'b0, bus.i_region_blocks});
            r_empty <= (w_fill_nxt == '0);

            if (w_flush) begin
                r_err <= 1'b0;
            end else if (w_stray) begin
                r_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_flush) begin
                        if (w_take_wr) begin
                            r_state        <= ST_WR_RUN;
                            r_busy         <= 1'b1;
                            r_ingress_en   <= 1'b1;
                            r_ingress_addr <= w_wr_start_addr;
                            r_cnt          <= '0;
                        end else if (w_take_rd) begin
                            r_state       <= ST_RD_RUN;
                            r_busy        <= 1'b1;
                            r_egress_en   <= 1'b1;
                            r_egress_addr <= w_rd_start_addr;
                            r_cnt         <= '0;
                        end
                    end
                end
                ST_WR_RUN: begin
                    if (bus.i_ingress_stb) begin
                        r_cnt        <= w_cnt_inc[BLOCK_W-1:0];
                        r_ingress_en <= 1'b0;
                        if (w_cnt_last) begin
                            r_state <= ST_WR_DRAIN;
                        end
                    end
                end
                ST_WR_DRAIN: begin
                    if (w_wr_done) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_last_op <= OP_WR;
                    end
                end
                ST_RD_RUN: begin
                    if (bus.i_egress_stb) begin
                        r_cnt       <= w_cnt_inc[BLOCK_W-1:0];
                        r_egress_en <= 1'b0;
                        if (w_cnt_last) begin
                            r_state <= ST_RD_DRAIN;
                        end
                    end
                end
                ST_RD_DRAIN: begin
                    if (w_rd_done) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_last_op <= OP_RD;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ingress_en         = r_ingress_en;
    assign bus.o_ingress_dword_addr = r_ingress_addr;
    assign bus.o_egress_en          = r_egress_en;
    assign bus.o_egress_dword_addr  = r_egress_addr;
    assign bus.o_fill_blocks        = r_fill;
    assign bus.o_full               = r_full;
    assign bus.o_empty              = r_empty;
    assign bus.o_busy               = r_busy;
    assign bus.o_err                = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_ring_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_ring_sched
// Purpose  : Self-checking bench for ddr3_ring_sched. A ring-FIFO model
//            (fill count, block indices, last operation) predicts which
//            operation is issued, its address and the resulting flags.
// Revision : 1.0  initial release
// ============================================================================
module tb_ddr3_ring_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr3_ring_sched_if #(.MEM_ADDR_DEPTH(28)) bus ();

    ddr3_ring_sched #(.MEM_ADDR_DEPTH(28)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Ring model
    int          region;
    int          blk;
    logic [25:0] base;
    int          m_fill;
    int          m_wr;
    int          m_rd;
    bit          m_last_wr;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ingress_en"},   64'(bus.o_ingress_en), 64'(0));
        check({tag, "_egress_en"},    64'(bus.o_egress_en), 64'(0));
        check({tag, "_ingress_addr"}, 64'(bus.o_ingress_dword_addr), 64'(0));
        check({tag, "_egress_addr"},  64'(bus.o_egress_dword_addr), 64'(0));
        check({tag, "_fill"},         64'(bus.o_fill_blocks), 64'(0));
        check({tag, "_empty"},        64'(bus.o_empty), 64'(1));
        check({tag, "_full"},         64'(bus.o_full), 64'(0));
        check({tag, "_busy"},         64'(bus.o_busy), 64'(0));
        check({tag, "_err"},          64'(bus.o_err), 64'(0));
    endtask

    task automatic model_clear();
        m_fill = 0;
        m_wr   = 0;
        m_rd   = 0;
    endtask

    function automatic logic [25:0] blk_addr(input int idx);
        return base + 26'(idx * blk);
    endfunction

    // Runs one complete block operation. Called at a negedge with inputs set.
    // drop_after > 0 lowers i_enable after that many strobes.
    task automatic do_block(input int gap_max, input int drain_max, input int drop_after);
        bit          wr_ok;
        bit          rd_ok;
        bit          exp_wr;
        int          t;
        logic [25:0] ea;
        logic [25:0] obs_addr;

        wr_ok  = bus.i_enable && (m_fill < region) && bus.i_ingress_rdy;
        rd_ok  = bus.i_enable && (m_fill > 0) && (bus.i_egress_rdy != 2'b00);
        exp_wr = wr_ok && (!rd_ok || !m_last_wr);
        ea     = blk_addr(exp_wr ? m_wr : m_rd);

        t = 0;
        while (!(bus.o_ingress_en || bus.o_egress_en) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("op_latency", 64'(t), 64'(1));
        if (t >= 20) return;

        check("op_is_write", 64'(bus.o_ingress_en), 64'(exp_wr));
        check("op_is_read",  64'(bus.o_egress_en), 64'(!exp_wr));
        obs_addr = exp_wr ? bus.o_ingress_dword_addr : bus.o_egress_dword_addr;
        check("op_addr", 64'(obs_addr), 64'(ea));
        check("op_busy", 64'(bus.o_busy), 64'(1));

        bus.i_app_idle = 1'b0;
        for (int k = 0; k < blk; k++) begin
            repeat (int'($urandom_range(gap_max, 0))) @(negedge clk);
            if (exp_wr) bus.i_ingress_stb = 1'b1;
            else        bus.i_egress_stb  = 1'b1;
            @(negedge clk);
            bus.i_ingress_stb = 1'b0;
            bus.i_egress_stb  = 1'b0;
            if (k == 0) check("en_drop", 64'(bus.o_ingress_en | bus.o_egress_en), 64'(0));
            if (k + 1 == drop_after) bus.i_enable = 1'b0;
        end

        repeat (int'($urandom_range(drain_max, 0))) @(negedge clk);
        check("drain_fill_hold", 64'(bus.o_fill_blocks), 64'(m_fill));
        check("drain_busy", 64'(bus.o_busy), 64'(1));
        obs_addr = exp_wr ? bus.o_ingress_dword_addr : bus.o_egress_dword_addr;
        check("addr_stable", 64'(obs_addr), 64'(ea));

        bus.i_app_idle = 1'b1;
        @(negedge clk);
        if (exp_wr) begin
            m_fill++;
            m_wr = (m_wr + 1 == region) ? 0 : m_wr + 1;
        end else begin
            m_fill--;
            m_rd = (m_rd + 1 == region) ? 0 : m_rd + 1;
        end
        m_last_wr = exp_wr;
        check("done_fill",  64'(bus.o_fill_blocks), 64'(m_fill));
        check("done_full",  64'(bus.o_full), 64'(m_fill == region));
        check("done_empty", 64'(bus.o_empty), 64'(m_fill == 0));
        check("done_busy",  64'(bus.o_busy), 64'(0));
    endtask

    task automatic set_config(input int r, input int b, input logic [25:0] ba);
        region = r;
        blk    = b;
        base   = ba;
        bus.i_region_blocks   = 16'(r);
        bus.i_block_dwords    = 24'(b);
        bus.i_base_dword_addr = ba;
    endtask

    initial begin
        bus.i_enable      = 1'b0;
        bus.i_flush       = 1'b0;
        bus.i_app_idle    = 1'b1;
        bus.i_ingress_rdy = 1'b0;
        bus.i_egress_rdy  = 2'b00;
        bus.i_ingress_stb = 1'b0;
        bus.i_egress_stb  = 1'b0;
        set_config(4, 8, 26'h100);
        model_clear();
        m_last_wr = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Fill the ring with four writes; a fifth is never issued.
        rst = 1'b0;
        bus.i_enable      = 1'b1;
        bus.i_ingress_rdy = 1'b1;
        repeat (4) do_block(1, 2, 0);
        check("full_flag", 64'(bus.o_full), 64'(1));
        repeat (5) @(negedge clk);
        check("no_fifth_write", 64'(bus.o_ingress_en), 64'(0));

        // Drain it with four reads.
        bus.i_ingress_rdy = 1'b0;
        bus.i_egress_rdy  = 2'b01;
        repeat (4) do_block(1, 2, 0);
        check("empty_flag", 64'(bus.o_empty), 64'(1));

        // Both sides always ready: strict alternation, write pointer wraps.
        bus.i_ingress_rdy = 1'b1;
        bus.i_egress_rdy  = 2'b11;
        repeat (12) do_block(1, 2, 0);

        // i_enable falls after the third strobe; block still completes.
        bus.i_egress_rdy = 2'b00;
        do_block(0, 2, 3);
        repeat (5) @(negedge clk);
        check("no_op_after_disable", 64'(bus.o_ingress_en | bus.o_egress_en), 64'(0));
        check("disable_fill_kept", 64'(bus.o_fill_blocks), 64'(m_fill));

        // Stray strobe in IDLE sets a sticky error; flush clears it and fill.
        bus.i_ingress_stb = 1'b1;
        @(negedge clk);
        bus.i_ingress_stb = 1'b0;
        check("err_set", 64'(bus.o_err), 64'(1));
        repeat (3) @(negedge clk);
        check("err_sticky", 64'(bus.o_err), 64'(1));
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        model_clear();
        check("flush_err", 64'(bus.o_err), 64'(0));
        check("flush_fill", 64'(bus.o_fill_blocks), 64'(0));
        check("flush_empty", 64'(bus.o_empty), 64'(1));

        // Reset in the middle of a read.
        bus.i_enable = 1'b1;
        do_block(1, 1, 0);
        bus.i_ingress_rdy = 1'b0;
        bus.i_egress_rdy  = 2'b10;
        begin
            int t;
            t = 0;
            while (!bus.o_egress_en && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("rd_for_reset_seen", 64'(bus.o_egress_en), 64'(1));
        end
        bus.i_app_idle = 1'b0;
        repeat (2) begin
            bus.i_egress_stb = 1'b1;
            @(negedge clk);
            bus.i_egress_stb = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        rst = 1'b0;
        model_clear();
        m_last_wr = 1'b0;
        bus.i_app_idle    = 1'b1;
        bus.i_ingress_rdy = 1'b1;
        bus.i_egress_rdy  = 2'b00;
        do_block(1, 1, 0);

        // Randomised traffic on fresh configurations.
        for (int c = 0; c < 3; c++) begin
            bus.i_enable = 1'b0;
            @(negedge clk);
            set_config(int'($urandom_range(5, 1)), 2 * int'($urandom_range(8, 1)), 26'($urandom));
            bus.i_flush = 1'b1;
            @(negedge clk);
            bus.i_flush = 1'b0;
            model_clear();
            check("cfg_flush_fill", 64'(bus.o_fill_blocks), 64'(0));
            for (int n = 0; n < 15; n++) begin
                bus.i_ingress_rdy = 1'($urandom_range(1, 0));
                bus.i_egress_rdy  = 2'($urandom_range(3, 0));
                if (!((m_fill < region) && bus.i_ingress_rdy) &&
                    !((m_fill > 0) && (bus.i_egress_rdy != 2'b00))) begin
                    if (m_fill < region) bus.i_ingress_rdy = 1'b1;
                    else                 bus.i_egress_rdy  = 2'b01;
                end
                bus.i_enable = 1'b1;
                do_block(2, 3, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr3_ring_sched.md
# ddr3_ring_sched

Block scheduler that uses a DDR3 region as a large ring FIFO between an ingress ping-pong FIFO and an egress ping-pong FIFO. It sits directly upstream of the DDR3 application-interface stage: it drives that stage's ingress/egress enables and dword addresses, counts its data strobes, and tracks ring pointers and fill level. Each operation moves exactly one block of `i_block_dwords` dwords.

## Interface
- `MEM_ADDR_DEPTH`, 28, DDR3 byte address width; dword addresses are `MEM_ADDR_DEPTH-2` bits.
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `i_enable`  in  1  allow new block operations.
- `i_flush`  in  1  pulse; clears pointers, fill and error. Honoured only in IDLE.
- `i_base_dword_addr`  in  MEM_ADDR_DEPTH-2  first dword of the ring region.
- `i_region_blocks`  in  16  ring size in blocks; must be ≥1.
- `i_block_dwords`  in  24  dwords per block; must be even and nonzero, and equal to the PPFIFO size.
- `i_app_idle`  in  1  application-interface stage is idle.
- `i_ingress_rdy`  in  1  an ingress PPFIFO buffer is ready.
- `i_egress_rdy`  in  2  an egress PPFIFO buffer is free.
- `o_ingress_en`  out  1  request a write block.
- `o_ingress_dword_addr`  out  MEM_ADDR_DEPTH-2  write block start address.
- `i_ingress_stb`  in  1  one dword popped from ingress.
- `o_egress_en`  out  1  request a read block.
- `o_egress_dword_addr`  out  MEM_ADDR_DEPTH-2  read block start address.
- `i_egress_stb`  in  1  one dword delivered to egress.
- `o_fill_blocks`  out  17  blocks currently stored.
- `o_full`, `o_empty`  out  1  `fill == region_blocks`, `fill == 0`.
- `o_busy`  out  1  state ≠ IDLE.
- `o_err`  out  1  sticky; set by a strobe outside RUN or by excess strobes.

## Operation
- States: IDLE, WR_RUN, WR_DRAIN, RD_RUN, RD_DRAIN.
- Write is eligible when `i_enable`, `!o_full` and `i_ingress_rdy` are all true.
- Read is eligible when `i_enable`, `!o_empty`, `i_egress_rdy != 0` and `i_app_idle` are all true.
- Write eligibility also requires `i_app_idle`.
- Arbitration in IDLE: if both are eligible, take the op opposite to `last_op`; `last_op` resets to read, so write wins first.
- IDLE→WR_RUN:
  - `o_ingress_en`←1.
  - `o_ingress_dword_addr`←`wr_addr`.
  - `cnt`←0.
- WR_RUN:
  - Each `i_ingress_stb` increments `cnt`.
  - `o_ingress_en` drops on the first strobe.
  - When `cnt` reaches `i_block_dwords`, go to WR_DRAIN.
- WR_DRAIN:
  - Wait for `i_app_idle`.
  - On exit: `wr_addr += block_dwords`; `wr_idx += 1`.
  - When `wr_idx` would equal `region_blocks`: `wr_idx`←0 and `wr_addr`←base.
  - `fill += 1`; `last_op`←write; go to IDLE.
- Read path: identical using `rd_addr`/`rd_idx` and the egress signals; `fill -= 1`.
- `fill` is updated only on DRAIN exit, so increment and decrement can never coincide.
- Blocks never straddle the region end, since the region is an integral number of blocks.
- Address arithmetic is modulo 2^(MEM_ADDR_DEPTH-2); no multiplier is used.
- `i_enable` falling mid-operation: the current block completes, then the block stays in IDLE with pointers and fill retained.
- `i_flush` in IDLE: `wr_idx`, `rd_idx` and fill ←0; `wr_addr` and `rd_addr` ←base; `o_err`←0.
- Reset mid-operation: everything returns to reset values. DDR contents are considered lost.
- A strobe in IDLE or DRAIN, or a count exceeding `i_block_dwords`, sets `o_err`. State flow is unaffected.

## Timing
- Reset values:
  - Both enables 0; both addresses 0.
  - `fill` 0; `o_empty` 1; `o_full` 0; `o_busy` 0; `o_err` 0.
  - Internal pointers are loaded from `i_base_dword_addr` on the first cycle after reset.
- Enable latency: eligibility sampled in cycle N gives the enable and address registered high at N+1.
- Enable is held until the first strobe, is low the cycle after that strobe, and never re-asserts within an op.
- The address is stable from enable assertion until DRAIN exit.
- Fill, pointer and flag updates are visible in the cycle after DRAIN sees `i_app_idle`=1.
- At least one IDLE cycle separates consecutive operations.
- Flags are registered and derived from `fill`.

## Structure
- Shared package `ddr3_ring_pkg`: state encoding, the `OP_WR`/`OP_RD` constants, and the fill width derived from 16-bit region blocks.
- One natural sub-module, `ring_ptr`, instantiated twice (write and read). It holds the `idx`/`addr` pair, with load-base, advance and wrap. The FSM, arbitration and fill counter stay in the top module.

## Test plan
- Region of 4 blocks, block 8 dwords, base 0x100: write 4 blocks → addresses 0x100, 0x108, 0x110, 0x118; fill 4; `o_full`=1; a fifth write is not issued.
- From full, read 4 blocks → read addresses 0x100..0x118 in order; `o_empty`=1.
- Interleave 6 writes and 6 reads with both always eligible → strict alternation starting with write; the write pointer wraps to 0x100 after 0x118.
- Drop `i_enable` after the 3rd strobe of a block → the block completes with 8 strobes, fill +1, then no new enable appears.
- Inject `i_ingress_stb` in IDLE → `o_err`=1 and held; `i_flush` clears it and resets fill to 0.
- Assert `rst` during RD_RUN → next cycle all outputs are at reset values; the first post-reset write goes to base.
